// File: rtl/partial_counter_window_if.sv
// Bus bundle for the multi-channel filter-window counter: sequencing controls,
// latched configuration inputs and registered address/status outputs.
interface partial_counter_window_if #(
    parameter int CONFIG_BIT = 4,
    parameter int CH_BIT     = 2,
    parameter int ADDR_W     = 8
);
    logic                  init;
    logic                  inc;
    logic [CONFIG_BIT-1:0] filter_size;
    logic [CH_BIT-1:0]     num_ch;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W-1:0]     ch_pitch;
    logic [CONFIG_BIT-1:0] cnt_out;
    logic [CH_BIT-1:0]     ch_out;
    logic [ADDR_W-1:0]     addr_out;
    logic                  cout;
    logic                  done;
    logic                  busy;

    modport master (
        output init, inc, filter_size, num_ch, base_addr, ch_pitch,
        input  cnt_out, ch_out, addr_out, cout, done, busy
    );

    modport slave (
        input  init, inc, filter_size, num_ch, base_addr, ch_pitch,
        output cnt_out, ch_out, addr_out, cout, done, busy
    );
endinterface

// File: rtl/partial_counter_window.sv
// Multi-channel filter-window counter: steps tap index per channel and emits
// a registered scratchpad address, a per-window wrap pulse and a sticky done.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | after reset; waiting for init, inc ignored
//  S_RUN  | stepping taps/channels on inc; busy=1
//  S_DONE | last tap of last channel consumed; done=1 until next init
module partial_counter_window #(
    parameter int CONFIG_BIT = 4,
    parameter int CH_BIT     = 2,
    parameter int ADDR_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    partial_counter_window_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CONFIG_BIT-1:0] CNT_ONE  = 1;
    localparam logic [CH_BIT-1:0]     CH_ONE   = 1;
    localparam logic [ADDR_W-1:0]     ADDR_ONE = 1;

    state_t                state_q, state_nx;
    logic [CONFIG_BIT-1:0] fs_last_q, fs_last_nx, cnt_q, cnt_nx;
    logic [CH_BIT-1:0]     nc_last_q, nc_last_nx, ch_q, ch_nx;
    logic [ADDR_W-1:0]     base_q, base_nx, pitch_q, pitch_nx;
    logic [ADDR_W-1:0]     ch_base_q, ch_base_nx, addr_q, addr_nx;
    logic                  cout_q, cout_nx, done_q, done_nx, busy_q, busy_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            fs_last_q <= '0;
            nc_last_q <= '0;
            base_q    <= '0;
            pitch_q   <= '0;
            ch_base_q <= '0;
            cnt_q     <= '0;
            ch_q      <= '0;
            addr_q    <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_nx;
            fs_last_q <= fs_last_nx;
            nc_last_q <= nc_last_nx;
            base_q    <= base_nx;
            pitch_q   <= pitch_nx;
            ch_base_q <= ch_base_nx;
            cnt_q     <= cnt_nx;
            ch_q      <= ch_nx;
            addr_q    <= addr_nx;
            cout_q    <= cout_nx;
            done_q    <= done_nx;
            busy_q    <= busy_nx;
        end
    end

    // Config is stored as last index (size-1) so a size of 0 behaves as 1.
    always_comb begin
        state_nx   = state_q;
        fs_last_nx = fs_last_q;
        nc_last_nx = nc_last_q;
        base_nx    = base_q;
        pitch_nx   = pitch_q;
        ch_base_nx = ch_base_q;
        cnt_nx     = cnt_q;
        ch_nx      = ch_q;
        addr_nx    = addr_q;
        cout_nx    = 1'b0;
        done_nx    = done_q;
        busy_nx    = busy_q;

        if (bus.init) begin
            fs_last_nx = (bus.filter_size == '0) ? '0 : bus.filter_size - CNT_ONE;
            nc_last_nx = (bus.num_ch == '0) ? '0 : bus.num_ch - CH_ONE;
            base_nx    = bus.base_addr;
            pitch_nx   = bus.ch_pitch;
            ch_base_nx = bus.base_addr;
            addr_nx    = bus.base_addr;
            cnt_nx     = '0;
            ch_nx      = '0;
            done_nx    = 1'b0;
            busy_nx    = 1'b1;
            state_nx   = S_RUN;
        end else if (bus.inc && state_q == S_RUN) begin
            if (cnt_q != fs_last_q) begin
                cnt_nx  = cnt_q + CNT_ONE;
                addr_nx = addr_q + ADDR_ONE;
            end else begin
                cnt_nx  = '0;
                cout_nx = 1'b1;
                if (ch_q != nc_last_q) begin
                    // Channel base advances by pitch; avoids a multiplier.
                    ch_nx      = ch_q + CH_ONE;
                    ch_base_nx = ch_base_q + pitch_q;
                    addr_nx    = ch_base_q + pitch_q;
                end else begin
                    ch_nx      = '0;
                    ch_base_nx = base_q;
                    addr_nx    = base_q;
                    done_nx    = 1'b1;
                    busy_nx    = 1'b0;
                    state_nx   = S_DONE;
                end
            end
        end
    end

    assign bus.cnt_out  = cnt_q;
    assign bus.ch_out   = ch_q;
    assign bus.addr_out = addr_q;
    assign bus.cout     = cout_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_partial_counter_window.sv
// Bench for partial_counter_window: directed scenarios plus random traffic,
// checked against a flat-index model of the tap/channel walk.
module tb_partial_counter_window;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    // model: position in the flattened (channel, tap) walk plus run status
    int m_fs, m_nc, m_base, m_pitch, m_pos, m_state, m_cout, m_done;

    partial_counter_window_if bus ();

    partial_counter_window dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] exp_vec();
        int tap;
        int chn;
        int adr;
        tap = m_pos % m_fs;
        chn = m_pos / m_fs;
        adr = (m_base + chn * m_pitch + tap) % 256;
        return {4'(tap), 2'(chn), 8'(adr), 1'(m_cout), 1'(m_done), (m_state == 1)};
    endfunction

    function automatic logic [16:0] act_vec();
        return {bus.cnt_out, bus.ch_out, bus.addr_out, bus.cout, bus.done, bus.busy};
    endfunction

    task automatic model_reset();
        m_fs = 1; m_nc = 1; m_base = 0; m_pitch = 0;
        m_pos = 0; m_state = 0; m_cout = 0; m_done = 0;
    endtask

    task automatic step(input logic i_init, input logic i_inc,
                        input int fs, input int nc, input int base, input int pitch);
        @(negedge clk);
        bus.init        = i_init;
        bus.inc         = i_inc;
        bus.filter_size = 4'(fs);
        bus.num_ch      = 2'(nc);
        bus.base_addr   = 8'(base);
        bus.ch_pitch    = 8'(pitch);
        @(posedge clk);
        if (rst_n) begin
            m_cout = 0;
            if (i_init) begin
                m_fs    = ((fs % 16) == 0) ? 1 : fs % 16;
                m_nc    = ((nc % 4) == 0) ? 1 : nc % 4;
                m_base  = base % 256;
                m_pitch = pitch % 256;
                m_pos   = 0;
                m_state = 1;
                m_done  = 0;
            end else if (i_inc && m_state == 1) begin
                m_pos = m_pos + 1;
                if (m_pos % m_fs == 0) m_cout = 1;
                if (m_pos == m_fs * m_nc) begin
                    m_pos   = 0;
                    m_state = 2;
                    m_done  = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.init = 0; bus.inc = 0; bus.filter_size = 0; bus.num_ch = 0;
        bus.base_addr = 0; bus.ch_pitch = 0;
        model_reset();
        #1;
        vectors++;
        if (act_vec() !== 17'h0) begin
            $display("FAIL reset_init got=%h want=%h", act_vec(), 17'h0); miscompares++;
        end
        @(negedge clk); rst_n = 1'b1;
        step(1, 0, 5, 3, 100, 20);
        for (int k = 0; k < 7; k++) step(0, 1, 5, 3, 100, 20);
        vectors++;
        if (act_vec() !== exp_vec()) begin
            $display("FAIL reset_prerun got=%h want=%h", act_vec(), exp_vec()); miscompares++;
        end
        // assert reset away from any clock edge
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (act_vec() !== 17'h0) begin
            $display("FAIL reset_async got=%h want=%h", act_vec(), 17'h0); miscompares++;
        end
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 5, 3, 100, 20);
            vectors++;
            if (act_vec() !== 17'h0) begin
                $display("FAIL reset_held got=%h want=%h", act_vec(), 17'h0); miscompares++;
            end
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 5, 3, 100, 20);
            vectors++;
            if (act_vec() !== 17'h0) begin
                $display("FAIL reset_idle_inc got=%h want=%h", act_vec(), 17'h0); miscompares++;
            end
        end
    endtask

    task automatic test_basic();
        int want_addr[6] = '{9, 10, 24, 25, 26, 8};
        int want_cnt[6]  = '{1, 2, 0, 1, 2, 0};
        int want_cout[6] = '{0, 0, 1, 0, 0, 1};
        step(1, 0, 3, 2, 8, 16);
        vectors++;
        if (bus.addr_out !== 8'd8 || bus.busy !== 1'b1 || act_vec() !== exp_vec()) begin
            $display("FAIL basic_init got=%h want=%h", act_vec(), exp_vec()); miscompares++;
        end
        for (int k = 0; k < 6; k++) begin
            step(0, 1, 3, 2, 8, 16);
            vectors++;
            if (bus.addr_out !== 8'(want_addr[k]) || bus.cnt_out !== 4'(want_cnt[k]) ||
                bus.cout !== 1'(want_cout[k]) || act_vec() !== exp_vec()) begin
                $display("FAIL basic_seq k=%0d got=%h want=%h addr_want=%0d", k, act_vec(),
                         exp_vec(), want_addr[k]);
                miscompares++;
            end
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            $display("FAIL basic_done got=%b%b want=10", bus.done, bus.busy); miscompares++;
        end
    endtask

    task automatic test_degenerate();
        step(1, 0, 0, 0, 77, 5);
        step(0, 1, 0, 0, 77, 5);
        vectors++;
        if (bus.cout !== 1'b1 || bus.done !== 1'b1 || bus.addr_out !== 8'd77 ||
            act_vec() !== exp_vec()) begin
            $display("FAIL degenerate got=%h want=%h", act_vec(), exp_vec()); miscompares++;
        end
        step(0, 0, 0, 0, 77, 5);
        vectors++;
        if (bus.cout !== 1'b0 || act_vec() !== exp_vec()) begin
            $display("FAIL degenerate_pulse got=%h want=%h", act_vec(), exp_vec()); miscompares++;
        end
    endtask

    task automatic test_priority();
        step(1, 0, 4, 1, 64, 3);
        step(0, 1, 4, 1, 64, 3);
        step(0, 1, 4, 1, 64, 3);
        step(1, 1, 4, 1, 64, 3);
        vectors++;
        if (bus.cnt_out !== 4'd0 || act_vec() !== exp_vec()) begin
            $display("FAIL prio_init_inc got=%h want=%h", act_vec(), exp_vec()); miscompares++;
        end
        // filter_size driven to 2 mid-run; wrap must still occur after 4 taps
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 2, 3, 200, 9);
            vectors++;
            if (bus.cout !== (k == 3) || act_vec() !== exp_vec()) begin
                $display("FAIL prio_cfg_change k=%0d got=%h want=%h", k, act_vec(), exp_vec());
                miscompares++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 4, 1, 64, 3);
            vectors++;
            if (act_vec() !== exp_vec() || bus.done !== 1'b1 || bus.addr_out !== 8'd64) begin
                $display("FAIL prio_done_inc got=%h want=%h", act_vec(), exp_vec()); miscompares++;
            end
        end
    endtask

    task automatic test_addr_wrap();
        int want_addr[8] = '{251, 252, 253, 4, 5, 6, 7, 250};
        step(1, 0, 4, 2, 250, 10);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 4, 2, 250, 10);
            vectors++;
            if (bus.addr_out !== 8'(want_addr[k]) || act_vec() !== exp_vec()) begin
                $display("FAIL addr_wrap k=%0d got=%0d want=%0d", k, bus.addr_out, want_addr[k]);
                miscompares++;
            end
        end
    endtask

    task automatic test_restart_gaps();
        int want_addr[6] = '{9, 10, 24, 25, 26, 8};
        step(1, 0, 3, 2, 8, 16);
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.addr_out !== 8'd8) begin
            $display("FAIL restart got=%h want=%h", act_vec(), exp_vec()); miscompares++;
        end
        for (int k = 0; k < 6; k++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step(0, 0, 3, 2, 8, 16);
                vectors++;
                if (act_vec() !== exp_vec()) begin
                    $display("FAIL gap_hold got=%h want=%h", act_vec(), exp_vec()); miscompares++;
                end
            end
            step(0, 1, 3, 2, 8, 16);
            vectors++;
            if (bus.addr_out !== 8'(want_addr[k]) || act_vec() !== exp_vec()) begin
                $display("FAIL gap_seq k=%0d got=%h want=%h", k, act_vec(), exp_vec());
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        int fs, nc, base, pitch;
        fs = $urandom_range(0, 15); nc = $urandom_range(0, 3);
        base = $urandom_range(0, 255); pitch = $urandom_range(0, 255);
        step(1, 0, fs, nc, base, pitch);
        for (int k = 0; k < 400; k++) begin
            logic do_init;
            do_init = ($urandom_range(0, 39) == 0);
            if (do_init) begin
                fs = $urandom_range(0, 15); nc = $urandom_range(0, 3);
                base = $urandom_range(0, 255); pitch = $urandom_range(0, 255);
            end
            step(do_init, 1'($urandom_range(0, 2) != 0), fs,
                 do_init ? nc : int'($urandom_range(0, 3)), base, pitch);
            vectors++;
            if (act_vec() !== exp_vec()) begin
                $display("FAIL random k=%0d got=%h want=%h", k, act_vec(), exp_vec());
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_degenerate();
        test_priority();
        test_addr_wrap();
        test_restart_gaps();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
